// File: rtl/windower_serial_pad.sv
// windower_serial_pad: slice-serial sliding-window generator with runtime
// frame length/stride and optional same-mode zero padding with self-flush.
module windower_serial_pad #(
    parameter int NO_CH_IN      = 16,
    parameter int LOG2_IMG_SIZE = 5,
    parameter int WINDOW_SIZE   = 3,
    parameter int SER_CYC       = 4,
    parameter int MAX_STRIDE    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LOG2_IMG_SIZE:0]                cfg_img_len,
    input  logic                                  cfg_pad_en,
    input  logic [$clog2(MAX_STRIDE):0]           cfg_stride,
    input  logic                                  vld_in,
    input  logic [NO_CH_IN-1:0]                   data_in,
    output logic                                  in_rdy,
    output logic                                  vld_out,
    output logic [WINDOW_SIZE-1:0][NO_CH_IN-1:0]  data_out,
    output logic                                  ser_rst,
    output logic [LOG2_IMG_SIZE-1:0]              win_idx,
    output logic                                  frame_end
);
    localparam int W     = WINDOW_SIZE;
    localparam int H     = (W - 1) / 2;
    localparam int LMAX  = 2 ** LOG2_IMG_SIZE;
    localparam int DEPTH = (W - 1) * SER_CYC;
    localparam int QW    = LOG2_IMG_SIZE + 2;
    localparam int CW    = LOG2_IMG_SIZE + 1;
    localparam int TW    = $clog2(MAX_STRIDE) + 1;
    localparam int SW    = (SER_CYC > 1) ? $clog2(SER_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t r_state, w_state_nxt;

    logic [QW-1:0]       r_len, r_q;
    logic [TW-1:0]       r_str, r_ph;
    logic                r_pad;
    logic [SW-1:0]       r_s;
    logic [NO_CH_IN-1:0] r_sh [DEPTH];

    logic [QW-1:0]       w_cfg_len, w_len, w_end_q, w_first;
    logic [TW-1:0]       w_cfg_str, w_str;
    logic                w_pad, w_idle, w_flush, w_acc, w_beat;
    logic                w_last_s, w_frame_last, w_in_last, w_emit;
    logic [NO_CH_IN-1:0] w_din;
    logic [LOG2_IMG_SIZE-1:0] w_o;
    logic [NO_CH_IN-1:0] w_hist [DEPTH+1];
    logic [W-1:0][NO_CH_IN-1:0] w_taps;

    always_comb begin
        w_cfg_len = QW'(cfg_img_len);
        if (cfg_img_len == '0 || cfg_img_len > CW'(LMAX))
            w_cfg_len = QW'(LMAX);
        else if (cfg_img_len < CW'(W))
            w_cfg_len = QW'(W);
        w_cfg_str = cfg_stride;
        if (cfg_stride == '0)
            w_cfg_str = TW'(1);
        else if (cfg_stride > TW'(MAX_STRIDE))
            w_cfg_str = TW'(MAX_STRIDE);
    end

    // Config is taken live on the frame's first beat, latched afterwards.
    assign w_idle  = (r_state == IDLE);
    assign w_len   = w_idle ? w_cfg_len : r_len;
    assign w_str   = w_idle ? w_cfg_str : r_str;
    assign w_pad   = w_idle ? cfg_pad_en : r_pad;

    assign w_flush = (r_state == FLUSH);
    assign in_rdy  = !w_flush;
    assign w_acc   = vld_in && in_rdy;
    assign w_beat  = w_acc || w_flush;
    assign w_din   = w_flush ? '0 : data_in;

    assign w_last_s     = (r_s == SW'(SER_CYC - 1));
    assign w_end_q      = w_len - QW'(1) + (w_pad ? QW'(H) : QW'(0));
    assign w_frame_last = w_last_s && (r_q == w_end_q);
    assign w_in_last    = w_last_s && (r_q == w_len - QW'(1));
    assign w_first      = w_pad ? QW'(H) : QW'(W - 1);
    assign w_emit       = (r_q >= w_first) && (r_ph == '0);
    assign w_o          = LOG2_IMG_SIZE'(r_q - w_first);

    // Taps outside 0..L-1 of the current frame read as zero.
    always_comb begin
        w_hist[0] = w_din;
        for (int k = 1; k <= DEPTH; k++)
            w_hist[k] = r_sh[k-1];
        w_taps = '0;
        for (int j = 0; j < W; j++) begin
            if (r_q >= QW'(W - 1 - j) && (r_q - QW'(W - 1 - j)) < w_len)
                w_taps[j] = w_hist[(W - 1 - j) * SER_CYC];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_beat) begin
            if (w_frame_last)
                w_state_nxt = IDLE;
            else if (w_in_last && w_pad)
                w_state_nxt = FLUSH;
            else if (w_idle)
                w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_str     <= '0;
            r_pad     <= 1'b0;
            r_q       <= '0;
            r_s       <= '0;
            r_ph      <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_sh[k] <= '0;
            vld_out   <= 1'b0;
            ser_rst   <= 1'b0;
            frame_end <= 1'b0;
            win_idx   <= '0;
            data_out  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            vld_out   <= w_beat && w_emit;
            ser_rst   <= w_beat && w_emit && (r_s == '0);
            frame_end <= w_beat && w_frame_last;
            if (w_idle && w_acc) begin
                r_len <= w_cfg_len;
                r_str <= w_cfg_str;
                r_pad <= cfg_pad_en;
            end
            if (w_beat) begin
                data_out <= w_taps;
                if (w_emit)
                    win_idx <= w_o;
                r_sh[0] <= w_din;
                for (int k = 1; k < DEPTH; k++)
                    r_sh[k] <= r_sh[k-1];
                // Stride phase steps once per window-eligible sample.
                if (w_frame_last) begin
                    r_s  <= '0;
                    r_q  <= '0;
                    r_ph <= '0;
                end else if (w_last_s) begin
                    r_s <= '0;
                    r_q <= r_q + QW'(1);
                    if (r_q >= w_first)
                        r_ph <= (r_ph == w_str - TW'(1)) ? '0 : r_ph + TW'(1);
                end else begin
                    r_s <= r_s + SW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_windower_serial_pad.sv
// tb_windower_serial_pad: directed and random frames, every cycle checked
// against a sample-indexed reference model plus literal pins.
module tb_windower_serial_pad;
    localparam int NC   = 16;
    localparam int LG   = 5;
    localparam int W    = 3;
    localparam int SC   = 4;
    localparam int MS   = 4;
    localparam int H    = 1;
    localparam int LMAX = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LG:0]       cfg_img_len = '0;
    logic              cfg_pad_en = 1'b0;
    logic [2:0]        cfg_stride = '0;
    logic              vld_in = 1'b0;
    logic [NC-1:0]     data_in = '0;
    logic              in_rdy, vld_out, ser_rst, frame_end;
    logic [W-1:0][NC-1:0] data_out;
    logic [LG-1:0]     win_idx;

    windower_serial_pad #(
        .NO_CH_IN(NC), .LOG2_IMG_SIZE(LG), .WINDOW_SIZE(W),
        .SER_CYC(SC), .MAX_STRIDE(MS)
    ) dut (
        .clk(clk), .rst(rst), .cfg_img_len(cfg_img_len),
        .cfg_pad_en(cfg_pad_en), .cfg_stride(cfg_stride),
        .vld_in(vld_in), .data_in(data_in), .in_rdy(in_rdy),
        .vld_out(vld_out), .data_out(data_out), .ser_rst(ser_rst),
        .win_idx(win_idx), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int  m_L, m_S, m_q, m_s;
    bit  m_pad, m_act, m_flush;
    logic [NC-1:0] mem [LMAX][SC];

    bit  e_vld, e_ser, e_fe, e_rdy;
    int  e_win;
    logic [W-1:0][NC-1:0] e_data;

    int  n_vld, n_ser, n_fe, n_rlo, last_win;
    int  b_vld, b_ser, b_fe, b_rlo;
    logic [W-1:0][NC-1:0] cap0, cap7;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int norm_len(input int c);
        if (c == 0 || c > LMAX) return LMAX;
        if (c < W) return W;
        return c;
    endfunction

    function automatic int norm_str(input int c);
        if (c == 0) return 1;
        if (c > MS) return MS;
        return c;
    endfunction

    // Reference: taps and window selection from sample indices directly.
    task automatic model_step();
        int idx, o;
        bit beat;
        e_vld = 0; e_ser = 0; e_fe = 0;
        if (rst) begin
            m_act = 0; m_flush = 0; m_q = 0; m_s = 0;
            e_win = 0; e_data = '0; e_rdy = 1;
            return;
        end
        beat = m_flush || vld_in;
        if (beat) begin
            if (!m_flush && !m_act) begin
                m_L = norm_len(int'(cfg_img_len));
                m_S = norm_str(int'(cfg_stride));
                m_pad = cfg_pad_en;
                m_act = 1;
            end
            if (!m_flush) mem[m_q][m_s] = data_in;
            for (int j = 0; j < W; j++) begin
                idx = m_q - (W - 1) + j;
                if (idx < 0 || idx >= m_L) e_data[j] = '0;
                else e_data[j] = mem[idx][m_s];
            end
            o = m_pad ? m_q - H : m_q - (W - 1);
            if (o >= 0 && (o % m_S) == 0) begin
                e_vld = 1;
                e_win = o;
                e_ser = (m_s == 0);
            end
            if (m_s == SC - 1) begin
                m_s = 0;
                if (m_q == m_L - 1 + (m_pad ? H : 0)) begin
                    e_fe = 1; m_q = 0; m_act = 0; m_flush = 0;
                end else begin
                    if (m_pad && m_q == m_L - 1) m_flush = 1;
                    m_q++;
                end
            end else begin
                m_s++;
            end
        end
        e_rdy = !m_flush;
    endtask

    task automatic compare();
        chk("vld_out", 64'(vld_out), 64'(e_vld));
        chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
        chk("frame_end", 64'(frame_end), 64'(e_fe));
        if (e_vld) begin
            chk("data_out", 64'(data_out), 64'(e_data));
            chk("win_idx", 64'(win_idx), 64'(e_win));
            chk("ser_rst", 64'(ser_rst), 64'(e_ser));
        end else begin
            chk("ser_rst_idle", 64'(ser_rst), 64'(0));
        end
        if (vld_out) n_vld++;
        if (frame_end) n_fe++;
        if (!in_rdy) n_rlo++;
        if (vld_out && ser_rst) begin
            n_ser++;
            last_win = int'(win_idx);
            if (win_idx == 0) cap0 = data_out;
            if (win_idx == 7) cap7 = data_out;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        vld_in = 0;
        repeat (n) tick();
    endtask

    task automatic snap();
        b_vld = n_vld; b_ser = n_ser; b_fe = n_fe; b_rlo = n_rlo;
    endtask

    task automatic send_frame(input int cl, input bit pad, input int cst,
                              input int gap, input bit rnd, input bit chg);
        int n, guard;
        bit acc;
        n = norm_len(cl);
        cfg_img_len = cl[LG:0];
        cfg_pad_en = pad;
        cfg_stride = cst[2:0];
        for (int q = 0; q < n; q++) begin
            for (int s = 0; s < SC; s++) begin
                while (gap > 0 && $urandom_range(99) < gap) begin
                    vld_in = 0;
                    data_in = 16'($urandom);
                    tick();
                end
                vld_in = 1;
                data_in = rnd ? 16'($urandom) : {q[7:0], 4'h0, s[3:0]};
                acc = 0;
                guard = 0;
                while (!acc) begin
                    acc = in_rdy;
                    tick();
                    if (chg) begin
                        cfg_img_len = 6'($urandom);
                        cfg_pad_en = 1'($urandom);
                        cfg_stride = 3'($urandom);
                    end
                    guard++;
                    if (guard > 50) begin
                        chk("rdy_timeout", 64'(in_rdy), 64'(1));
                        vld_in = 0;
                        return;
                    end
                end
            end
        end
        vld_in = 0;
    endtask

    initial begin
        n_vld = 0; n_ser = 0; n_fe = 0; n_rlo = 0; last_win = -1;
        cap0 = '0; cap7 = '0;
        rst = 1;
        tick();
        tick();
        chk("rst_vld", 64'(vld_out), 64'(0));
        chk("rst_data", 64'(data_out), 64'(0));
        chk("rst_win", 64'(win_idx), 64'(0));
        chk("rst_fe", 64'(frame_end), 64'(0));
        rst = 0;
        tick();
        chk("rst_rdy", 64'(in_rdy), 64'(1));

        snap();
        send_frame(32, 0, 1, 0, 0, 0);
        idle(6);
        chk("v1_beats", 64'(n_vld - b_vld), 64'(120));
        chk("v1_wins", 64'(n_ser - b_ser), 64'(30));
        chk("v1_last", 64'(last_win), 64'(29));
        chk("v1_fe", 64'(n_fe - b_fe), 64'(1));
        chk("v1_first", 64'(cap0), 64'({16'h0200, 16'h0100, 16'h0000}));

        snap();
        send_frame(32, 0, 2, 0, 0, 0);
        idle(6);
        chk("s2_beats", 64'(n_vld - b_vld), 64'(60));
        chk("s2_ser", 64'(n_ser - b_ser), 64'(15));
        chk("s2_last", 64'(last_win), 64'(28));

        snap();
        send_frame(8, 1, 1, 0, 0, 0);
        idle(8);
        chk("p_wins", 64'(n_ser - b_ser), 64'(8));
        chk("p_w0", 64'(cap0), 64'({16'h0100, 16'h0000, 16'h0000}));
        chk("p_w7", 64'(cap7), 64'({16'h0000, 16'h0700, 16'h0600}));
        chk("p_rdylo", 64'(n_rlo - b_rlo), 64'(4));
        chk("p_fe", 64'(n_fe - b_fe), 64'(1));

        snap();
        send_frame(32, 0, 1, 50, 0, 0);
        idle(6);
        chk("g_beats", 64'(n_vld - b_vld), 64'(120));
        chk("g_wins", 64'(n_ser - b_ser), 64'(30));

        snap();
        send_frame(8, 1, 1, 0, 0, 0);
        tick();
        rst = 1;
        tick();
        chk("ab_vld", 64'(vld_out), 64'(0));
        chk("ab_ser", 64'(ser_rst), 64'(0));
        chk("ab_data", 64'(data_out), 64'(0));
        chk("ab_win", 64'(win_idx), 64'(0));
        rst = 0;
        idle(6);
        chk("ab_nofe", 64'(n_fe - b_fe), 64'(0));
        snap();
        send_frame(5, 0, 1, 0, 0, 0);
        idle(4);
        chk("ab_wins", 64'(n_ser - b_ser), 64'(3));
        chk("ab_w0", 64'(cap0), 64'({16'h0200, 16'h0100, 16'h0000}));

        snap();
        send_frame(0, 0, 1, 0, 0, 0);
        idle(4);
        chk("c0_wins", 64'(n_ser - b_ser), 64'(30));
        snap();
        send_frame(2, 0, 1, 0, 0, 0);
        idle(4);
        chk("c2_wins", 64'(n_ser - b_ser), 64'(1));
        snap();
        send_frame(32, 0, 7, 0, 0, 0);
        idle(4);
        chk("s7_wins", 64'(n_ser - b_ser), 64'(8));
        chk("s7_last", 64'(last_win), 64'(28));
        snap();
        send_frame(8, 0, 1, 0, 0, 1);
        idle(4);
        chk("chg_wins", 64'(n_ser - b_ser), 64'(6));

        for (int f = 0; f < 20; f++) begin
            send_frame($urandom_range(0, 40), 1'($urandom), $urandom_range(0, 7),
                       $urandom_range(0, 60), 1, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
